// File: rtl/safe_pkg.sv
// Shared constants for the safe front end.
// Lane indices, clock rate and default key timing.
package safe_pkg;

  localparam int KEY_RESET = 0;
  localparam int KEY_ENTER = 1;

  localparam int CLK_HZ = 50_000_000;

  localparam int DEF_N_KEYS          = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_HOLD_CYCLES     = 50_000_000;

endpackage

// File: rtl/key_lane.sv
// One pushbutton lane: 2-FF sync, debounce, hold timer.
// Emits a clean level plus press/release/hold pulses.
module key_lane
  import safe_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES
) (
  input  logic clk,
  input  logic RESETN,
  input  logic key_n_raw_i,
  output logic key_level_o,
  output logic press_pulse_o,
  output logic release_pulse_o,
  output logic hold_pulse_o
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int HD_W = $clog2(HOLD_CYCLES + 1);

  localparam logic [DB_W-1:0] DB_LAST =
    DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HD_W-1:0] HD_MAX =
    HD_W'(HOLD_CYCLES);
  localparam logic [HD_W-1:0] HD_LAST =
    HD_W'(HOLD_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            stable_q, stable_d;
  logic [DB_W-1:0] db_q, db_d;
  logic [HD_W-1:0] hold_q, hold_d;
  logic            press_q, press_d;
  logic            rel_q, rel_d;
  logic            holdp_q, holdp_d;
  logic            s;

  assign s = ~sync2_q;

  // Debounce and hold next-state; a release always wins over hold.
  always_comb begin
    stable_d = stable_q;
    db_d     = db_q;
    hold_d   = hold_q;
    press_d  = 1'b0;
    rel_d    = 1'b0;
    holdp_d  = 1'b0;
    if (s == stable_q) begin
      db_d = '0;
    end else if (db_q == DB_LAST) begin
      stable_d = s;
      db_d     = '0;
      press_d  = s;
      rel_d    = ~s;
    end else begin
      db_d = db_q + DB_W'(1);
    end
    if (rel_d) begin
      hold_d = '0;
    end else if (stable_q && hold_q != HD_MAX) begin
      hold_d  = hold_q + HD_W'(1);
      holdp_d = (hold_q == HD_LAST);
    end
  end

  // State and output flops; reset forces the released state.
  always_ff @(posedge clk) begin
    if (!RESETN) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b0;
      db_q     <= '0;
      hold_q   <= '0;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
      holdp_q  <= 1'b0;
    end else begin
      sync1_q  <= key_n_raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      db_q     <= db_d;
      hold_q   <= hold_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
      holdp_q  <= holdp_d;
    end
  end

  assign key_level_o     = stable_q;
  assign press_pulse_o   = press_q;
  assign release_pulse_o = rel_q;
  assign hold_pulse_o    = holdp_q;

endmodule

// File: rtl/key_conditioner.sv
// Pushbutton front end: one independent key_lane per key.
// Only wiring lives here; all timing is inside key_lane.
module key_conditioner
  import safe_pkg::*;
#(
  parameter int N_KEYS          = DEF_N_KEYS,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES
) (
  input  logic              clk,
  input  logic              RESETN,
  input  logic [N_KEYS-1:0] key_n_raw,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] hold_pulse
);

  for (genvar g = 0; g < N_KEYS; g++) begin : g_lane
    key_lane #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES)
    ) u_lane (
      .clk             (clk),
      .RESETN          (RESETN),
      .key_n_raw_i     (key_n_raw[g]),
      .key_level_o     (key_level[g]),
      .press_pulse_o   (press_pulse[g]),
      .release_pulse_o (release_pulse[g]),
      .hold_pulse_o    (hold_pulse[g])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner with short debounce/hold times.
// Expected pulses are queued by cycle and checked every clock.
module tb_key_conditioner;

  localparam int NK  = 2;
  localparam int DB  = 4;
  localparam int HC  = 12;
  localparam int LAT = DB + 2;

  localparam int K_P = 0;
  localparam int K_R = 1;
  localparam int K_H = 2;

  logic          clk = 1'b0;
  logic          RESETN = 1'b0;
  logic [NK-1:0] key_n_raw = '1;
  logic [NK-1:0] key_level;
  logic [NK-1:0] press_pulse;
  logic [NK-1:0] release_pulse;
  logic [NK-1:0] hold_pulse;

  key_conditioner #(
    .N_KEYS          (NK),
    .DEBOUNCE_CYCLES (DB),
    .HOLD_CYCLES     (HC)
  ) dut (
    .clk           (clk),
    .RESETN        (RESETN),
    .key_n_raw     (key_n_raw),
    .key_level     (key_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .hold_pulse    (hold_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    int at;
    int lane;
    int kind;
  } ev_t;

  ev_t           sb[$];
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_err = 0;
  bit            chk = 1'b0;
  logic [NK-1:0] exp_lvl = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_ev(int lane, int kind, int at);
    ev_t e;
    int  i;
    e.at   = at;
    e.lane = lane;
    e.kind = kind;
    i = 0;
    while (i < sb.size() && sb[i].at <= at) i++;
    sb.insert(i, e);
  endtask

  task automatic wait_cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: pop events due this cycle and compare all outputs.
  always @(negedge clk) begin : mon
    logic [NK-1:0] ep, er, eh, lv;
    ev_t e;
    if (chk) begin
      ep = '0;
      er = '0;
      eh = '0;
      while (sb.size() > 0 && sb[0].at < cyc) begin
        e = sb.pop_front();
        n_cmp++;
        n_err++;
        $display("FAIL sb_missed: event lane %0d kind %0d due %0d not seen by %0d",
                 e.lane, e.kind, e.at, cyc);
      end
      while (sb.size() > 0 && sb[0].at == cyc) begin
        e = sb.pop_front();
        if (e.kind == K_P) ep[e.lane] = 1'b1;
        else if (e.kind == K_R) er[e.lane] = 1'b1;
        else eh[e.lane] = 1'b1;
      end
      lv = (exp_lvl | ep) & ~er;
      n_cmp++;
      if (press_pulse !== ep) begin
        n_err++;
        $display("FAIL press_pulse @%0d: got %b want %b", cyc, press_pulse, ep);
      end
      n_cmp++;
      if (release_pulse !== er) begin
        n_err++;
        $display("FAIL release_pulse @%0d: got %b want %b", cyc, release_pulse, er);
      end
      n_cmp++;
      if (hold_pulse !== eh) begin
        n_err++;
        $display("FAIL hold_pulse @%0d: got %b want %b", cyc, hold_pulse, eh);
      end
      n_cmp++;
      if (key_level !== lv) begin
        n_err++;
        $display("FAIL key_level @%0d: got %b want %b", cyc, key_level, lv);
      end
      exp_lvl <= lv;
    end
  end

  task automatic test_reset();
    logic [4*NK-1:0] all;
    RESETN    = 1'b0;
    key_n_raw = '1;
    @(posedge clk);
    #1;
    chk = 1'b1;
    wait_cyc(2);
    all = {key_level, press_pulse, release_pulse, hold_pulse};
    n_cmp++;
    if (all !== '0) begin
      n_err++;
      $display("FAIL reset_in: got %b want 0", all);
    end
    RESETN = 1'b1;
    wait_cyc(20);
    all = {key_level, press_pulse, release_pulse, hold_pulse};
    n_cmp++;
    if (all !== '0) begin
      n_err++;
      $display("FAIL reset_idle: got %b want 0", all);
    end
  endtask

  task automatic test_clean_press();
    int c;
    int r;
    c = cyc;
    key_n_raw[1] = 1'b0;
    expect_ev(1, K_P, c + LAT);
    wait_cyc(LAT - 1);
    n_cmp++;
    if (key_level !== 2'b00) begin
      n_err++;
      $display("FAIL clean_early: got %b want 00", key_level);
    end
    wait_cyc(1);
    n_cmp++;
    if ({key_level, press_pulse} !== 4'b1010) begin
      n_err++;
      $display("FAIL clean_edge: got %b want 1010", {key_level, press_pulse});
    end
    wait_cyc(1);
    n_cmp++;
    if (press_pulse !== 2'b00) begin
      n_err++;
      $display("FAIL clean_one_cycle: got %b want 00", press_pulse);
    end
    wait_cyc(1);
    r = cyc;
    key_n_raw[1] = 1'b1;
    expect_ev(1, K_R, r + LAT);
    wait_cyc(LAT);
    n_cmp++;
    if (key_level !== 2'b00) begin
      n_err++;
      $display("FAIL clean_release: got %b want 00", key_level);
    end
    wait_cyc(8);
  endtask

  task automatic test_bounce();
    int f;
    int r;
    for (int i = 0; i < 4; i++) begin
      key_n_raw[1] = (i % 2 == 1);
      wait_cyc(2);
    end
    key_n_raw[1] = 1'b0;
    f = cyc;
    n_cmp++;
    if (key_level !== 2'b00) begin
      n_err++;
      $display("FAIL bounce_quiet: got %b want 00", key_level);
    end
    expect_ev(1, K_P, f + LAT);
    wait_cyc(LAT);
    n_cmp++;
    if (key_level !== 2'b10) begin
      n_err++;
      $display("FAIL bounce_level: got %b want 10", key_level);
    end
    r = cyc;
    key_n_raw[1] = 1'b1;
    expect_ev(1, K_R, r + LAT);
    wait_cyc(10);
  endtask

  task automatic test_hold_release();
    int c;
    int r;
    c = cyc;
    key_n_raw[1] = 1'b0;
    expect_ev(1, K_P, c + LAT);
    expect_ev(1, K_H, c + LAT + HC);
    wait_cyc(30);
    n_cmp++;
    if (key_level !== 2'b10) begin
      n_err++;
      $display("FAIL hold_level: got %b want 10", key_level);
    end
    r = cyc;
    key_n_raw[1] = 1'b1;
    expect_ev(1, K_R, r + LAT);
    wait_cyc(LAT - 1);
    n_cmp++;
    if (key_level !== 2'b10) begin
      n_err++;
      $display("FAIL release_early: got %b want 10", key_level);
    end
    wait_cyc(1);
    n_cmp++;
    if ({key_level, release_pulse} !== 4'b0010) begin
      n_err++;
      $display("FAIL release_edge: got %b want 0010", {key_level, release_pulse});
    end
    wait_cyc(10);
  endtask

  task automatic test_reset_mid();
    int r;
    logic [4*NK-1:0] all;
    key_n_raw[1] = 1'b0;
    wait_cyc(4);
    RESETN = 1'b0;
    wait_cyc(2);
    all = {key_level, press_pulse, release_pulse, hold_pulse};
    n_cmp++;
    if (all !== '0) begin
      n_err++;
      $display("FAIL mid_reset_clear: got %b want 0", all);
    end
    RESETN = 1'b1;
    r = cyc;
    expect_ev(1, K_P, r + LAT);
    wait_cyc(LAT);
    n_cmp++;
    if (key_level !== 2'b10) begin
      n_err++;
      $display("FAIL mid_reset_repress: got %b want 10", key_level);
    end
    wait_cyc(2);
    key_n_raw[1] = 1'b1;
    expect_ev(1, K_R, cyc + LAT);
    wait_cyc(10);
  endtask

  task automatic test_simultaneous();
    int c;
    int r;
    c = cyc;
    key_n_raw = 2'b00;
    for (int l = 0; l < NK; l++) begin
      expect_ev(l, K_P, c + LAT);
      expect_ev(l, K_H, c + LAT + HC);
    end
    wait_cyc(20);
    n_cmp++;
    if (key_level !== 2'b11) begin
      n_err++;
      $display("FAIL simul_level: got %b want 11", key_level);
    end
    r = cyc;
    key_n_raw = 2'b11;
    for (int l = 0; l < NK; l++) expect_ev(l, K_R, r + LAT);
    wait_cyc(10);
    n_cmp++;
    if (key_level !== 2'b00) begin
      n_err++;
      $display("FAIL simul_release: got %b want 00", key_level);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_hold_release();
    test_reset_mid();
    test_simultaneous();
    wait_cyc(2);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover: got %0d events want 0", sb.size());
    end
    chk = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
